noc_input_unit: RTL and testbench

- Parametrised NoC router input port that supersedes the fixed port logic of the current router.
- Buffers incoming flits in a Depth-entry FIFO.
- Tracks packet framing using the head/tail preamble.
- Computes XY route on each head flit and locks that route until the tail flit leaves.
- Returns flow control upstream in either ack-nack or credit-based mode, selected by parameter.
- One instance sits on each router input (N/S/W/E/local) ahead of the switch allocator.

---
 rtl/noc.sv | 21 ++
 rtl/noc_input_unit.sv | 137 +++++++++++++
 tb/tb_noc_input_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/noc.sv
// Shared NoC types and constants used by the router blocks.
package noc;

  localparam int unsigned xWidth = 4;
  localparam int unsigned yWidth = 4;

  typedef enum logic {
    kFlowControlAckNack,
    kFlowControlCreditBased
  } noc_flow_control_t;

  // One-hot output direction request
  typedef logic [4:0] direction_t;

  localparam direction_t DirNorth = 5'b00001;
  localparam direction_t DirSouth = 5'b00010;
  localparam direction_t DirWest  = 5'b00100;
  localparam direction_t DirEast  = 5'b01000;
  localparam direction_t DirLocal = 5'b10000;

endpackage

// File: rtl/noc_input_unit.sv
// Router input port: flit FIFO, head/tail framing, XY route with per-packet
// lock, and ack-nack or credit upstream flow control.
module noc_input_unit #(
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned Depth = 4,
  parameter noc::noc_flow_control_t FlowControl = noc::kFlowControlCreditBased,
  parameter int unsigned XW = noc::xWidth,
  parameter int unsigned YW = noc::yWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XW+YW-1:0]           position,
  input  logic [FlitWidth-1:0]       data_in,
  input  logic                       data_in_valid,
  output logic                       in_ready,
  output logic                       credit_out,
  output logic [FlitWidth-1:0]       data_out,
  output logic                       out_valid,
  output logic [4:0]                 out_route,
  input  logic                       out_ready,
  output logic [$clog2(Depth):0]     count,
  output logic                       err_protocol,
  output logic                       err_overflow
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;
  // Header layout from MSB: head, tail, src_y, src_x, dst_y, dst_x, msg_type, payload
  localparam int unsigned DstYLsb = FlitWidth - 2 - 2 * YW - XW;
  localparam int unsigned DstXLsb = DstYLsb - XW;

  typedef enum logic {StIdle, StBody} state_e;

  logic [FlitWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CountW-1:0]    count_q;
  state_e               state_q, state_d;
  noc::direction_t      lock_q, lock_d, xy_route;

  logic [FlitWidth-1:0] head_flit;
  logic                 non_empty, full, flit_head, flit_tail;
  logic                 drop, accept, pop, push;
  logic [XW-1:0]        dst_x, pos_x;
  logic [YW-1:0]        dst_y, pos_y;

  assign head_flit = mem_q[rd_ptr_q];
  assign flit_head = head_flit[FlitWidth-1];
  assign flit_tail = head_flit[FlitWidth-2];
  assign dst_x     = head_flit[DstXLsb +: XW];
  assign dst_y     = head_flit[DstYLsb +: YW];
  assign pos_x     = position[XW-1:0];
  assign pos_y     = position[XW+YW-1:XW];

  assign non_empty = (count_q != '0);
  assign full      = (count_q == CountW'(Depth));

  // Framing violations are popped silently: body outside a packet, head inside one
  assign drop      = non_empty && ((state_q == StIdle) ? !flit_head : flit_head);
  assign out_valid = non_empty && !drop;
  assign accept    = out_valid && out_ready;
  assign pop       = accept || drop;
  assign push      = data_in_valid && (!full || pop);

  assign data_out     = head_flit;
  assign count        = count_q;
  assign err_protocol = drop;
  assign err_overflow = data_in_valid && full && !pop;
  assign in_ready     = (FlowControl == noc::kFlowControlAckNack) ? !full : 1'b1;
  // Only delivered flits return a credit; dropped ones are reported via err_protocol
  assign credit_out   = (FlowControl == noc::kFlowControlCreditBased) ? accept : 1'b0;

  // Dimension-ordered XY route of the FIFO head entry
  always_comb begin
    xy_route = noc::DirLocal;
    if (dst_x > pos_x) begin
      xy_route = noc::DirEast;
    end else if (dst_x < pos_x) begin
      xy_route = noc::DirWest;
    end else if (dst_y > pos_y) begin
      xy_route = noc::DirSouth;
    end else if (dst_y < pos_y) begin
      xy_route = noc::DirNorth;
    end
  end

  // Packet framing FSM and route lock
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    out_route = '0;
    if (out_valid) begin
      out_route = (state_q == StBody) ? lock_q : xy_route;
    end
    case (state_q)
      StIdle: begin
        if (accept && !flit_tail) begin
          state_d = StBody;
          lock_d  = xy_route;
        end
      end
      StBody: begin
        if (accept && flit_tail) begin
          state_d = StIdle;
          lock_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointers, occupancy and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      lock_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CountW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CountW'(1);
      end
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Flit storage; contents are qualified by count so need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_noc_input_unit.sv
// Bench for noc_input_unit: ack-nack and credit instances share stimulus and
// are compared against a queue-based packet model.
module tb_noc_input_unit;

  localparam int unsigned FW = 64;
  localparam int unsigned Depth = 4;
  localparam int unsigned XW = noc::xWidth;
  localparam int unsigned YW = noc::yWidth;
  localparam int unsigned CW = $clog2(Depth) + 1;
  localparam int unsigned DstYLsb = FW - 2 - 2 * YW - XW;
  localparam int unsigned DstXLsb = DstYLsb - XW;

  localparam logic [4:0] DirN = 5'b00001;
  localparam logic [4:0] DirS = 5'b00010;
  localparam logic [4:0] DirW = 5'b00100;
  localparam logic [4:0] DirE = 5'b01000;
  localparam logic [4:0] DirL = 5'b10000;

  logic clk = 1'b0;
  logic rst;
  logic [XW+YW-1:0] position;
  logic [FW-1:0] data_in;
  logic data_in_valid, out_ready;

  logic a_in_ready, a_credit_out, a_out_valid, a_err_protocol, a_err_overflow;
  logic [FW-1:0] a_data_out;
  logic [4:0] a_out_route;
  logic [CW-1:0] a_count;
  logic c_in_ready, c_credit_out, c_out_valid, c_err_protocol, c_err_overflow;
  logic [FW-1:0] c_data_out;
  logic [4:0] c_out_route;
  logic [CW-1:0] c_count;

  always #5 clk = ~clk;

  noc_input_unit #(
    .FlitWidth(FW), .Depth(Depth), .FlowControl(noc::kFlowControlAckNack), .XW(XW), .YW(YW)
  ) u_ack (
    .clk(clk), .rst(rst), .position(position), .data_in(data_in),
    .data_in_valid(data_in_valid), .in_ready(a_in_ready), .credit_out(a_credit_out),
    .data_out(a_data_out), .out_valid(a_out_valid), .out_route(a_out_route),
    .out_ready(out_ready), .count(a_count), .err_protocol(a_err_protocol),
    .err_overflow(a_err_overflow)
  );

  noc_input_unit #(
    .FlitWidth(FW), .Depth(Depth), .FlowControl(noc::kFlowControlCreditBased), .XW(XW), .YW(YW)
  ) u_crd (
    .clk(clk), .rst(rst), .position(position), .data_in(data_in),
    .data_in_valid(data_in_valid), .in_ready(c_in_ready), .credit_out(c_credit_out),
    .data_out(c_data_out), .out_valid(c_out_valid), .out_route(c_out_route),
    .out_ready(out_ready), .count(c_count), .err_protocol(c_err_protocol),
    .err_overflow(c_err_overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued flits, in-packet flag and the route locked at the head
  logic [FW-1:0] mq[$];
  bit m_body = 1'b0;
  logic [4:0] m_lock = '0;
  int pos_x = 1;
  int pos_y = 1;
  int credits = 0;

  function automatic logic [4:0] ref_route(input logic [FW-1:0] f);
    int dx, dy;
    dx = int'(f[DstXLsb +: XW]);
    dy = int'(f[DstYLsb +: YW]);
    if (dx > pos_x) return DirE;
    if (dx < pos_x) return DirW;
    if (dy > pos_y) return DirS;
    if (dy < pos_y) return DirN;
    return DirL;
  endfunction

  function automatic logic [FW-1:0] mk(input bit h, input bit t, input int dx, input int dy);
    logic [FW-1:0] f;
    f = {$urandom, $urandom};
    f[FW-1] = h;
    f[FW-2] = t;
    f[DstYLsb +: YW] = YW'(dy);
    f[DstXLsb +: XW] = XW'(dx);
    return f;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge
  task automatic step(input bit v, input logic [FW-1:0] d, input bit r, input bit rs);
    logic [FW-1:0] f, popped;
    bit drop, exp_valid, acc, pop, ovf;
    logic [4:0] exp_route;
    int n;
    rst = rs;
    data_in_valid = v;
    data_in = d;
    out_ready = r;
    n = mq.size();
    f = (n > 0) ? mq[0] : '0;
    drop = (n > 0) && (m_body ? f[FW-1] : !f[FW-1]);
    exp_valid = (n > 0) && !drop;
    exp_route = !exp_valid ? 5'b0 : (m_body ? m_lock : ref_route(f));
    acc = exp_valid && r;
    pop = acc || drop;
    ovf = v && (n == Depth) && !pop;
    @(negedge clk);
    if (!rs) begin
      check("count_a", 64'(a_count), 64'(n));
      check("count_c", 64'(c_count), 64'(n));
      check("valid_a", 64'(a_out_valid), 64'(exp_valid));
      check("valid_c", 64'(c_out_valid), 64'(exp_valid));
      check("route_a", 64'(a_out_route), 64'(exp_route));
      check("route_c", 64'(c_out_route), 64'(exp_route));
      check("in_ready_a", 64'(a_in_ready), 64'(n < Depth));
      check("in_ready_c", 64'(c_in_ready), 64'(1));
      check("credit_a", 64'(a_credit_out), 64'(0));
      check("credit_c", 64'(c_credit_out), 64'(acc));
      check("err_prot_a", 64'(a_err_protocol), 64'(drop));
      check("err_prot_c", 64'(c_err_protocol), 64'(drop));
      check("err_ovf_a", 64'(a_err_overflow), 64'(ovf));
      check("err_ovf_c", 64'(c_err_overflow), 64'(ovf));
      if (exp_valid) begin
        check("data_a", a_data_out, f);
        check("data_c", c_data_out, f);
      end
      if (c_credit_out) credits++;
    end
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_body = 1'b0;
      m_lock = '0;
    end else begin
      if (pop) begin
        popped = mq.pop_front();
        if (acc) begin
          if (!m_body && !popped[FW-2]) begin
            m_body = 1'b1;
            m_lock = exp_route;
          end else if (m_body && popped[FW-2]) begin
            m_body = 1'b0;
            m_lock = '0;
          end
        end
      end
      if (v && (n < Depth || pop)) mq.push_back(d);
    end
    #1;
  endtask

  task automatic send(input bit h, input bit t, input int dx, input int dy, input bit r);
    step(1'b1, mk(h, t, dx, dy), r, 1'b0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_in = '0;
    out_ready = 1'b0;
    position = {YW'(1), XW'(1)};
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // XY routing from {y=1,x=1}: east, north, south, local, west
    send(1, 1, 3, 1, 1);
    send(1, 1, 1, 0, 1);
    send(1, 1, 1, 2, 1);
    send(1, 1, 1, 1, 1);
    send(1, 1, 0, 1, 1);
    idle(3);

    // Route lock over a 4-flit packet; body flits carry misleading dst fields
    credits = 0;
    send(1, 0, 3, 1, 0);
    send(0, 0, 0, 0, 1);
    send(0, 0, 1, 0, 0);
    send(0, 1, 1, 2, 1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, (i % 2) == 0, 1'b0);
    check("credits_pkt", 64'(credits), 64'(4));

    // Fill, overflow, then push with pop on a full FIFO
    send(1, 0, 2, 1, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 1);
    send(0, 1, 0, 0, 1);
    idle(6);

    // Protocol errors: body in idle, head inside a packet
    send(0, 0, 3, 3, 1);
    idle(2);
    send(1, 0, 1, 0, 1);
    send(1, 0, 3, 1, 1);
    send(0, 1, 3, 1, 1);
    idle(4);

    // Back-to-back: single-flit packet then 2-flit packet, always ready
    send(1, 1, 0, 1, 1);
    send(1, 0, 1, 2, 1);
    send(0, 1, 3, 3, 1);
    idle(3);

    // Reset mid-packet with three flits queued, then a fresh head
    send(1, 0, 3, 1, 0);
    send(0, 0, 0, 0, 1);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    step(1'b0, '0, 1'b0, 1'b1);
    send(1, 1, 0, 1, 1);
    idle(2);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, '0, 1'b0, 1'b1);
      end else begin
        step($urandom_range(0, 9) < 7,
             mk($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
             $urandom_range(0, 9) < 6, 1'b0);
      end
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
